// File: rtl/dbg_cmd_bridge_pkg.sv
// rtl/dbg_cmd_bridge_pkg.sv - shared bus codes, opcode bytes and FSM encoding for the debug command bridge
package dbg_cmd_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ADDR  = 3'd1,
        ST_GET_DATA  = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_SEND      = 3'd5
    } state_t;

    localparam logic [2:0] MCMD_IDLE = 3'b000;
    localparam logic [2:0] MCMD_WR   = 3'b001;
    localparam logic [2:0] MCMD_RD   = 3'b010;

    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;

    localparam logic [7:0] OPC_WRITE = 8'h57;
    localparam logic [7:0] OPC_READ  = 8'h52;
    localparam logic [7:0] OPC_ABORT = 8'h1B;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OPC_WRITE) || (b == OPC_READ);
    endfunction

endpackage

// File: rtl/dbg_cmd_bridge_if.sv
// rtl/dbg_cmd_bridge_if.sv - RX/TX byte streams and debug bus signals of the command bridge
interface dbg_cmd_bridge_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [2:0] bus_MCmd;
    logic [7:0] bus_MAddr;
    logic [7:0] bus_MData;
    logic       bus_SCmdAccept;
    logic [7:0] bus_SData;
    logic [1:0] bus_SResp;
    logic       busy;

    modport master (
        input  rx_valid, rx_data, tx_ready, bus_SCmdAccept, bus_SData, bus_SResp,
        output rx_ready, tx_valid, tx_data, bus_MCmd, bus_MAddr, bus_MData, busy
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, bus_SCmdAccept, bus_SData, bus_SResp,
        input  rx_ready, tx_valid, tx_data, bus_MCmd, bus_MAddr, bus_MData, busy
    );
endinterface

// File: rtl/dbg_resp_timer.sv
// rtl/dbg_resp_timer.sv - read-response timeout counter, built only with DBG_CMD_BRIDGE_TIMEOUT_EN
module dbg_resp_timer #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    logic [7:0] count;

    // Held at zero outside WAIT_RESP, so every entry starts a fresh count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (!run) begin
            count <= 8'd0;
        end else if (!expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = run && (count == (LIMIT - 8'd1));

endmodule

// File: rtl/dbg_cmd_bridge.sv
// rtl/dbg_cmd_bridge.sv - byte-stream command parser and single-outstanding debug bus master
// Optional read timeout enabled by defining DBG_CMD_BRIDGE_TIMEOUT_EN.
module dbg_cmd_bridge
    import dbg_cmd_bridge_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYC = 8'd255,
    parameter logic [7:0] ACK_CHAR    = 8'h4B,
    parameter logic [7:0] NAK_CHAR    = 8'h3F,
    parameter logic [7:0] ERR_CHAR    = 8'h45
) (
    input  logic             clk,
    input  logic             reset,
    dbg_cmd_bridge_if.master dbg
);

    state_t     state, state_nxt;
    logic       op_wr, op_wr_nxt;
    logic [7:0] maddr, maddr_nxt;
    logic [7:0] mdata, mdata_nxt;
    logic [2:0] mcmd, mcmd_nxt;
    logic [7:0] tx_data_r, tx_data_nxt;
    logic       rx_fire;
    logic       cmd_accepted;
    logic       resp_dva;
    logic       timed_out;

    assign rx_fire      = dbg.rx_valid && dbg.rx_ready;
    assign cmd_accepted = dbg.bus_SCmdAccept && (mcmd != MCMD_IDLE);
    assign resp_dva     = (dbg.bus_SResp == SRESP_DVA);

`ifdef DBG_CMD_BRIDGE_TIMEOUT_EN
    dbg_resp_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_resp_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (state == ST_WAIT_RESP),
        .expired (timed_out)
    );
`else
    logic unused_cfg;
    assign timed_out  = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_wr     <= 1'b0;
            maddr     <= 8'h00;
            mdata     <= 8'h00;
            mcmd      <= MCMD_IDLE;
            tx_data_r <= 8'h00;
        end else begin
            state     <= state_nxt;
            op_wr     <= op_wr_nxt;
            maddr     <= maddr_nxt;
            mdata     <= mdata_nxt;
            mcmd      <= mcmd_nxt;
            tx_data_r <= tx_data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        op_wr_nxt   = op_wr;
        maddr_nxt   = maddr;
        mdata_nxt   = mdata;
        mcmd_nxt    = mcmd;
        tx_data_nxt = tx_data_r;
        case (state)
            ST_IDLE: begin
                if (rx_fire) begin
                    if (is_opcode(dbg.rx_data)) begin
                        op_wr_nxt = (dbg.rx_data == OPC_WRITE);
                        state_nxt = ST_GET_ADDR;
                    end else begin
                        tx_data_nxt = NAK_CHAR;
                        state_nxt   = ST_SEND;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_fire) begin
                    if (dbg.rx_data == OPC_ABORT) begin
                        maddr_nxt = 8'h00;
                        mdata_nxt = 8'h00;
                        state_nxt = ST_IDLE;
                    end else begin
                        maddr_nxt = dbg.rx_data;
                        state_nxt = op_wr ? ST_GET_DATA : ST_ISSUE;
                    end
                end
            end
            ST_GET_DATA: begin
                if (rx_fire) begin
                    if (dbg.rx_data == OPC_ABORT) begin
                        maddr_nxt = 8'h00;
                        mdata_nxt = 8'h00;
                        state_nxt = ST_IDLE;
                    end else begin
                        mdata_nxt = dbg.rx_data;
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // First ISSUE cycle loads MCmd; it then holds until the slave accepts.
                if (cmd_accepted) begin
                    mcmd_nxt = MCMD_IDLE;
                    if (op_wr) begin
                        tx_data_nxt = ACK_CHAR;
                        state_nxt   = ST_SEND;
                    end else begin
                        state_nxt = ST_WAIT_RESP;
                    end
                end else if (mcmd == MCMD_IDLE) begin
                    mcmd_nxt = op_wr ? MCMD_WR : MCMD_RD;
                end
            end
            ST_WAIT_RESP: begin
                if (resp_dva) begin
                    tx_data_nxt = dbg.bus_SData;
                    state_nxt   = ST_SEND;
                end else if (timed_out) begin
                    tx_data_nxt = ERR_CHAR;
                    state_nxt   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (dbg.tx_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dbg.rx_ready  = (state == ST_IDLE) || (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    assign dbg.tx_valid  = (state == ST_SEND);
    assign dbg.tx_data   = tx_data_r;
    assign dbg.bus_MCmd  = mcmd;
    assign dbg.bus_MAddr = maddr;
    assign dbg.bus_MData = mdata;
    assign dbg.busy      = (state != ST_IDLE);

endmodule
